// File: rtl/r121_rca.sv
// Registered 2-bit ripple-carry adder: two cascaded full-adder cells feeding
// output registers that capture {Cout,S1,S0} and a one-cycle valid flag.

// One-bit full adder cell; outputs are purely combinational.
module r121_rca_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s_c,
    output logic co_c
);

    logic p_c;

    assign p_c  = a ^ b;
    assign s_c  = p_c ^ ci;
    assign co_c = (a & b) | (ci & p_c);

endmodule

module r121_rca (
    input  logic clk,
    input  logic rst,
    input  logic A0,
    input  logic A1,
    input  logic B0,
    input  logic B1,
    input  logic Cin,
    input  logic in_valid,
    output logic S0,
    output logic S1,
    output logic Cout,
    output logic out_valid
);

    logic s0n_c;
    logic s1n_c;
    logic c1_c;
    logic coutn_c;

    // Carry ripples from the bit-0 cell into the bit-1 cell.
    r121_rca_fa u_fa0 (
        .a    (A0),
        .b    (B0),
        .ci   (Cin),
        .s_c  (s0n_c),
        .co_c (c1_c)
    );

    r121_rca_fa u_fa1 (
        .a    (A1),
        .b    (B1),
        .ci   (c1_c),
        .s_c  (s1n_c),
        .co_c (coutn_c)
    );

    // Result holds when no valid input arrives; reset overrides a same-cycle operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            S0        <= 1'b0;
            S1        <= 1'b0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S0   <= s0n_c;
                S1   <= s1n_c;
                Cout <= coutn_c;
            end
        end
    end

endmodule

// File: tb/tb_r121_rca.sv
// Self-checking bench for r121_rca: reset, exhaustive sweep, carry corners,
// hold behaviour, reset mid-stream and a randomized stream against an arithmetic model.

module tb_r121_rca;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic A0 = 1'b0;
    logic A1 = 1'b0;
    logic B0 = 1'b0;
    logic B1 = 1'b0;
    logic Cin = 1'b0;
    logic in_valid = 1'b0;
    logic S0;
    logic S1;
    logic Cout;
    logic out_valid;

    int vectors = 0;
    int errors  = 0;

    r121_rca dut (
        .clk       (clk),
        .rst       (rst),
        .A0        (A0),
        .A1        (A1),
        .B0        (B0),
        .B1        (B1),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .S0        (S0),
        .S1        (S1),
        .Cout      (Cout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference: plain integer addition of the two operands and carry-in.
    function automatic logic [2:0] ref_sum(input logic [1:0] a, input logic [1:0] b, input logic c);
        int s;
        s = int'(a) + int'(b) + int'(c);
        return 3'(s);
    endfunction

    // Drive one cycle of inputs, let one rising edge pass, then settle before sampling.
    task automatic apply(input logic [1:0] a, input logic [1:0] b, input logic c,
                         input logic v, input logic r);
        {A1, A0} = a;
        {B1, B0} = b;
        Cin      = c;
        in_valid = v;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(2'($urandom), 2'($urandom), 1'($urandom), 1'b1, 1'b1);
            vectors++;
            if ({Cout, S1, S0, out_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got {Cout,S1,S0,v}=%b, expected 0000", i, {Cout, S1, S0, out_valid});
            end
        end
        for (int i = 0; i < 2; i++) begin
            apply(2'($urandom), 2'($urandom), 1'($urandom), 1'b0, 1'b0);
            vectors++;
            if ({Cout, S1, S0, out_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_release[%0d]: got {Cout,S1,S0,v}=%b, expected 0000", i, {Cout, S1, S0, out_valid});
            end
        end
    endtask

    task automatic test_sweep();
        logic [4:0] pat;
        logic [2:0] exp;
        for (int i = 0; i < 32; i++) begin
            pat = 5'(i);
            exp = ref_sum({pat[3], pat[4]}, {pat[1], pat[2]}, pat[0]);
            apply({pat[3], pat[4]}, {pat[1], pat[2]}, pat[0], 1'b1, 1'b0);
            vectors++;
            if ({Cout, S1, S0} !== exp || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sweep[%0d]: got sum=%b v=%b, expected sum=%b v=1", i, {Cout, S1, S0}, out_valid, exp);
            end
        end
    endtask

    task automatic test_corners();
        logic [1:0] ta [5] = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
        logic [1:0] tb [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
        logic       tc [5] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
        logic [2:0] te [5] = '{3'b010, 3'b100, 3'b111, 3'b001, 3'b000};
        for (int i = 0; i < 5; i++) begin
            apply(ta[i], tb[i], tc[i], 1'b1, 1'b0);
            vectors++;
            if ({Cout, S1, S0} !== te[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL corner[%0d]: got sum=%b v=%b, expected sum=%b v=1", i, {Cout, S1, S0}, out_valid, te[i]);
            end
        end
    endtask

    task automatic test_hold();
        apply(2'b10, 2'b01, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({Cout, S1, S0} !== 3'b011 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_load: got sum=%b v=%b, expected sum=011 v=1", {Cout, S1, S0}, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            apply(2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
            vectors++;
            if ({Cout, S1, S0} !== 3'b011 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got sum=%b v=%b, expected sum=011 v=0", i, {Cout, S1, S0}, out_valid);
            end
        end
    endtask

    task automatic test_reset_stream();
        apply(2'b11, 2'b10, 1'b1, 1'b1, 1'b0);
        vectors++;
        if ({Cout, S1, S0} !== 3'b110 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got sum=%b v=%b, expected sum=110 v=1", {Cout, S1, S0}, out_valid);
        end
        apply(2'b11, 2'b11, 1'b0, 1'b1, 1'b1);
        vectors++;
        if ({Cout, S1, S0, out_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_stream: got {Cout,S1,S0,v}=%b, expected 0000", {Cout, S1, S0, out_valid});
        end
        apply(2'b01, 2'b11, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({Cout, S1, S0} !== 3'b100 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_first: got sum=%b v=%b, expected sum=100 v=1", {Cout, S1, S0}, out_valid);
        end
    endtask

    // Random stream with gaps: model remembers the last valid sum.
    task automatic test_random();
        logic [1:0] a;
        logic [1:0] b;
        logic       c;
        logic       v;
        logic [2:0] last;
        last = 3'b100;
        for (int i = 0; i < 300; i++) begin
            a = 2'($urandom);
            b = 2'($urandom);
            c = 1'($urandom);
            v = ($urandom_range(0, 3) != 0);
            if (v) last = ref_sum(a, b, c);
            apply(a, b, c, v, 1'b0);
            vectors++;
            if ({Cout, S1, S0} !== last || out_valid !== v) begin
                errors++;
                $display("FAIL random[%0d]: got sum=%b v=%b, expected sum=%b v=%b", i, {Cout, S1, S0}, out_valid, last, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_corners();
        test_hold();
        test_reset_stream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/r121_rca.md
# r121_rca

Registered 2-bit ripple-carry adder. Two full-adder stages add operand bits A1:A0 and B1:B0 plus carry-in Cin. The 3-bit result {Cout,S1,S0} is captured in output registers. It is a leaf arithmetic block: it feeds wider datapaths or serves as a standalone adder cell, and is exhaustively verifiable over all 32 input combinations.

## Interface
Parameters:
- None. Operand width is fixed at 2 bits.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, synchronous, active-high
- A0  input  1  operand A, bit 0 (LSB)
- A1  input  1  operand A, bit 1 (MSB)
- B0  input  1  operand B, bit 0 (LSB)
- B1  input  1  operand B, bit 1 (MSB)
- Cin  input  1  carry into bit 0
- in_valid  input  1  operands and Cin are valid this cycle
- S0  output  1  registered sum bit 0
- S1  output  1  registered sum bit 1
- Cout  output  1  registered carry out of bit 1
- out_valid  output  1  registered; high when S0/S1/Cout hold a result computed from a valid input

## Operation
- Arithmetic:
  - {Cout,S1,S0} = {A1,A0} + {B1,B0} + Cin, computed without truncation.
  - Range 0..7.
- Structure: two cascaded full adders. Carry ripples from stage 0 to stage 1.
  - Stage 0: S0n = A0^B0^Cin; c1 = (A0&B0)|(Cin&(A0^B0)).
  - Stage 1: S1n = A1^B1^c1; Coutn = (A1&B1)|(c1&(A1^B1)).
  - Each full adder is a separate, reusable submodule instantiated twice.
- Registers (rising clk):
  - if rst: S0, S1, Cout, out_valid <= 0.
  - else if in_valid: S0 <= S0n; S1 <= S1n; Cout <= Coutn; out_valid <= 1.
  - else: S0/S1/Cout hold their previous values; out_valid <= 0.
- No X propagation is permitted from the registers after reset. Inputs are sampled only at the clock edge.
- There is no backpressure. A result is presented for exactly one cycle with out_valid=1 and remains on S0/S1/Cout until overwritten or reset.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N, with out_valid=1 during cycle N+1.
- Throughput: one addition per cycle. Back-to-back in_valid cycles produce back-to-back results.
- Reset value of every output: S0=0, S1=0, Cout=0, out_valid=0.
- Reset takes effect at the first rising clk with rst=1 and has priority over in_valid.
- Reset mid-stream: an operation sampled in the same cycle as rst=1 is discarded. Results already on the outputs are cleared at that edge.
- After rst deasserts, the first in_valid cycle produces a result one cycle later.
- Critical path: Cin -> c1 -> Coutn, which is two full-adder carry delays and must close within one clk period.

## Test plan
- Reset check: hold rst=1 for 2 cycles with arbitrary inputs and in_valid=1 -> S0=S1=Cout=out_valid=0. Deassert rst -> outputs remain 0 until the first valid result.
- Exhaustive sweep: all 32 combinations of (A0,A1,B0,B1,Cin) with in_valid=1, one per cycle -> each result one cycle later equals A+B+Cin. Scoreboard against a reference sum.
- Carry ripple corners:
  - A=01, B=01, Cin=0 -> Cout=0, S1=1, S0=0.
  - A=01, B=10, Cin=1 -> Cout=1, S1=0, S0=0.
  - A=11, B=11, Cin=1 -> Cout=1, S1=1, S0=1.
- Zero case: A=00, B=00, Cin=1 -> Cout=0, S1=0, S0=1. With Cin=0 -> all 0.
- Hold behaviour: apply valid A=10, B=01, Cin=0, then drop in_valid and change inputs -> outputs stay S1=1, S0=1, Cout=0; out_valid=1 for one cycle, then 0.
- Reset during stream: issue valid A=11, B=11, Cin=0 with rst=1 in the same cycle -> next cycle outputs all 0 and out_valid=0.
